// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding, switch indices and 7-segment constants
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } state_t;

   localparam int PSW_START  = 3;
   localparam int PSW_LAP    = 2;
   localparam int PSW_CLEAR  = 1;
   localparam int PSW_RECALL = 0;

   localparam int SEG_DP      = 7;
   localparam int DP_DIGIT    = 2;
   localparam int TENS_S_DIG  = 3;

   // Segment order {g,f,e,d,c,b,a}; codes above 9 never occur and stay dark.
   function automatic logic [6:0] seg_pattern(input logic [3:0] bcd);
      case (bcd)
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         4'd3:    return 7'h4F;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6D;
         4'd6:    return 7'h7D;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   function automatic logic [3:0] digit_max(input int idx);
      return (idx == TENS_S_DIG) ? 4'd5 : 4'd9;
   endfunction

endpackage

// File: rtl/seg7_dec.sv
// rtl/seg7_dec.sv - BCD digit plus decimal point to active-high segment byte
module seg7_dec
   import stopwatch_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       dp,
   output logic [7:0] seg
);

   assign seg = {dp, seg_pattern(bcd)};

endmodule

// File: rtl/stopwatch_lap.sv
// rtl/stopwatch_lap.sv - BCD stopwatch with lap memory, recall view and 7-segment outputs
module stopwatch_lap
   import stopwatch_pkg::*;
#(
   parameter int N_DIG     = 4,
   parameter int TICK_DIV  = 10,
   parameter int LAP_DEPTH = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [3:0]           PSW,
   input  logic [3:0]           RSW,
   output logic [8*N_DIG-1:0]   SEG,
   output logic [7:0]           LED
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int AW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
   localparam int CW = AW + 1;

   state_t                    state, state_nxt;
   logic [3:0]                psw_r, psw_d, edges;
   logic                      press_ss, press_clear, press_lap, press_recall;
   logic                      run, clear_go, lap_go, recall_go;
   logic [PW-1:0]             pre;
   logic                      tick, wrap, ovf;
   logic [N_DIG-1:0][3:0]     dig, dig_nxt;
   logic [N_DIG-1:0][3:0]     lap_mem [LAP_DEPTH];
   logic [AW-1:0]             wr_ptr, oldest, view_idx, rd_addr;
   logic [CW-1:0]             count;
   logic                      full, view;
   logic [4:0]                cnt5;
   logic [3:0]                cnt_led;
   logic [N_DIG-1:0][3:0]     shown;
   logic [N_DIG-1:0][7:0]     seg_c, seg_q;
   logic [7:0]                led_c;
   logic                      unused_rsw;

   assign unused_rsw = ^RSW[3:1];

   // Registers start all-ones so a switch held through reset release is not a press.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         psw_r <= 4'hF;
         psw_d <= 4'hF;
      end else begin
         psw_r <= PSW;
         psw_d <= psw_r;
      end
   end

   assign edges        = psw_r & ~psw_d;
   assign press_clear  = edges[PSW_CLEAR];
   assign press_ss     = edges[PSW_START] & ~press_clear;
   assign press_lap    = edges[PSW_LAP] & ~edges[PSW_START] & ~press_clear;
   assign press_recall = edges[PSW_RECALL] & ~edges[PSW_LAP] & ~edges[PSW_START] & ~press_clear;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (press_ss) state_nxt = ST_RUN;
         ST_RUN:  if (press_ss) state_nxt = ST_STOP;
         ST_STOP: begin
            if (press_clear)   state_nxt = ST_IDLE;
            else if (press_ss) state_nxt = ST_RUN;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      run       = (state == ST_RUN);
      clear_go  = (state == ST_STOP) && press_clear;
      lap_go    = (state == ST_RUN) && press_lap;
      recall_go = (state == ST_STOP) && press_recall && (count != '0);
   end

   assign tick = run && (pre == PW'(TICK_DIV - 1));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)           pre <= '0;
      else if (clear_go) pre <= '0;
      else if (run)      pre <= tick ? '0 : pre + 1'b1;
   end

   // Ripple carry through the digits; a carry out of the top leaves every digit at zero.
   always_comb begin
      logic carry;
      carry   = tick;
      dig_nxt = dig;
      for (int i = 0; i < N_DIG; i++) begin
         if (carry) begin
            if (dig[i] == digit_max(i)) begin
               dig_nxt[i] = 4'd0;
            end else begin
               dig_nxt[i] = dig[i] + 4'd1;
               carry      = 1'b0;
            end
         end
      end
      wrap = carry;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         dig <= '0;
         ovf <= 1'b0;
      end else if (clear_go) begin
         dig <= '0;
         ovf <= 1'b0;
      end else begin
         dig <= dig_nxt;
         if (wrap) ovf <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (lap_go) lap_mem[wr_ptr] <= dig;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr   <= '0;
         oldest   <= '0;
         count    <= '0;
         view_idx <= '0;
      end else if (clear_go) begin
         wr_ptr   <= '0;
         oldest   <= '0;
         count    <= '0;
         view_idx <= '0;
      end else if (lap_go) begin
         wr_ptr   <= wr_ptr + 1'b1;
         view_idx <= '0;
         if (full) oldest <= oldest + 1'b1;
         else      count  <= count + 1'b1;
      end else if (recall_go) begin
         view_idx <= ({1'b0, view_idx} == count - CW'(1)) ? '0 : view_idx + 1'b1;
      end
   end

   assign full    = (count == CW'(LAP_DEPTH));
   assign view    = RSW[0] && (count != '0);
   assign rd_addr = oldest + view_idx;
   assign shown   = view ? lap_mem[rd_addr] : dig;

   genvar g;
   for (g = 0; g < N_DIG; g++) begin : g_dec
      seg7_dec u_dec (
         .bcd (shown[g]),
         .dp  (1'(g == DP_DIGIT)),
         .seg (seg_c[g])
      );
   end

   assign cnt5    = 5'(count);
   assign cnt_led = cnt5[4] ? 4'hF : cnt5[3:0];
   assign led_c   = {cnt_led, view, full, ovf, run};

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < N_DIG; i++) seg_q[i] <= {i == DP_DIGIT, seg_pattern(4'd0)};
         LED <= 8'h00;
      end else begin
         seg_q <= seg_c;
         LED   <= led_c;
      end
   end

   assign SEG = seg_q;

endmodule

// File: tb/tb_stopwatch_lap.sv
// tb/tb_stopwatch_lap.sv - directed self-checking bench for stopwatch_lap
module tb_stopwatch_lap;

   logic        CLK;
   logic        RST;
   logic [3:0]  PSW;
   logic [3:0]  RSW;
   logic [31:0] SEG;
   logic [7:0]  LED;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] S_0000 = 32'h3FBF3F3F;
   localparam logic [31:0] S_0001 = 32'h3FBF3F06;
   localparam logic [31:0] S_0002 = 32'h3FBF3F5B;
   localparam logic [31:0] S_0005 = 32'h3FBF3F6D;
   localparam logic [31:0] S_0010 = 32'h3FBF063F;
   localparam logic [31:0] S_0012 = 32'h3FBF065B;
   localparam logic [31:0] S_5999 = 32'h6DEF6F6F;

   stopwatch_lap #(.N_DIG(4), .TICK_DIV(10), .LAP_DEPTH(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .PSW (PSW),
      .RSW (RSW),
      .SEG (SEG),
      .LED (LED)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic wait_neg(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // Switch high for two edges; the action lands on the second, outputs settle on the third.
   task automatic press(input logic [3:0] m);
      @(negedge CLK);
      PSW = m;
      @(negedge CLK);
      @(negedge CLK);
      PSW = 4'b0000;
      @(negedge CLK);
   endtask

   task automatic test_reset;
      RST = 1'b1;
      wait_neg(2);
      checks++;
      if (SEG !== S_0000) begin errors++; $display("FAIL reset_seg: got %h want %h", SEG, S_0000); end
      checks++;
      if (LED !== 8'h00) begin errors++; $display("FAIL reset_led: got %h want %h", LED, 8'h00); end
      RST = 1'b0;
      wait_neg(2);
   endtask

   task automatic test_count;
      press(4'b1000);
      wait_neg(100);
      checks++;
      if (SEG !== S_0010) begin errors++; $display("FAIL count_seg: got %h want %h", SEG, S_0010); end
      checks++;
      if (LED !== 8'h01) begin errors++; $display("FAIL count_led: got %h want %h", LED, 8'h01); end
   endtask

   task automatic test_overflow;
      wait_neg(59894);
      checks++;
      if (SEG !== S_5999) begin errors++; $display("FAIL ovf_pre_seg: got %h want %h", SEG, S_5999); end
      checks++;
      if (LED !== 8'h01) begin errors++; $display("FAIL ovf_pre_led: got %h want %h", LED, 8'h01); end
      wait_neg(10);
      checks++;
      if (SEG !== S_0000) begin errors++; $display("FAIL ovf_wrap_seg: got %h want %h", SEG, S_0000); end
      checks++;
      if (LED !== 8'h03) begin errors++; $display("FAIL ovf_wrap_led: got %h want %h", LED, 8'h03); end
      wait_neg(10);
      checks++;
      if (SEG !== S_0001) begin errors++; $display("FAIL ovf_cont_seg: got %h want %h", SEG, S_0001); end
      checks++;
      if (LED !== 8'h03) begin errors++; $display("FAIL ovf_cont_led: got %h want %h", LED, 8'h03); end
   endtask

   task automatic test_priority_clear;
      press(4'b1000);
      press(4'b1010);
      checks++;
      if (SEG !== S_0000) begin errors++; $display("FAIL prio_clear_seg: got %h want %h", SEG, S_0000); end
      checks++;
      if (LED !== 8'h00) begin errors++; $display("FAIL prio_clear_led: got %h want %h", LED, 8'h00); end
   endtask

   task automatic test_clear_in_run;
      press(4'b1000);
      wait_neg(20);
      press(4'b0010);
      wait_neg(1);
      checks++;
      if (SEG !== S_0002) begin errors++; $display("FAIL run_clear_seg: got %h want %h", SEG, S_0002); end
      checks++;
      if (LED !== 8'h01) begin errors++; $display("FAIL run_clear_led: got %h want %h", LED, 8'h01); end
      press(4'b1000);
      press(4'b0010);
   endtask

   task automatic test_laps;
      press(4'b1000);
      wait_neg(52);
      press(4'b0100);
      wait_neg(67);
      press(4'b0100);
      press(4'b1000);
      RSW = 4'b0001;
      wait_neg(2);
      checks++;
      if (SEG !== S_0005) begin errors++; $display("FAIL lap_view0_seg: got %h want %h", SEG, S_0005); end
      checks++;
      if (LED !== 8'h28) begin errors++; $display("FAIL lap_view_led: got %h want %h", LED, 8'h28); end
      press(4'b0001);
      checks++;
      if (SEG !== S_0012) begin errors++; $display("FAIL lap_recall1_seg: got %h want %h", SEG, S_0012); end
      press(4'b0001);
      checks++;
      if (SEG !== S_0005) begin errors++; $display("FAIL lap_recall_wrap_seg: got %h want %h", SEG, S_0005); end
   endtask

   task automatic test_lap_full;
      RSW = 4'b0000;
      press(4'b0010);
      press(4'b1000);
      for (int i = 0; i < 5; i++) begin
         wait_neg((i == 0) ? 12 : 7);
         press(4'b0100);
      end
      press(4'b1000);
      RSW = 4'b0001;
      wait_neg(2);
      checks++;
      if (SEG !== S_0002) begin errors++; $display("FAIL full_oldest_seg: got %h want %h", SEG, S_0002); end
      checks++;
      if (LED !== 8'h4C) begin errors++; $display("FAIL full_led: got %h want %h", LED, 8'h4C); end
      for (int i = 0; i < 3; i++) press(4'b0001);
      checks++;
      if (SEG !== S_0005) begin errors++; $display("FAIL full_newest_seg: got %h want %h", SEG, S_0005); end
      press(4'b0001);
      checks++;
      if (SEG !== S_0002) begin errors++; $display("FAIL full_wrap_seg: got %h want %h", SEG, S_0002); end
   endtask

   task automatic test_async_reset;
      RSW = 4'b0000;
      press(4'b1000);
      wait_neg(30);
      #2;
      RST = 1'b1;
      PSW = 4'b1000;
      #1;
      checks++;
      if (SEG !== S_0000) begin errors++; $display("FAIL async_rst_seg: got %h want %h", SEG, S_0000); end
      checks++;
      if (LED !== 8'h00) begin errors++; $display("FAIL async_rst_led: got %h want %h", LED, 8'h00); end
      wait_neg(2);
      RST = 1'b0;
      wait_neg(5);
      checks++;
      if (LED !== 8'h00) begin errors++; $display("FAIL held_start_led: got %h want %h", LED, 8'h00); end
      checks++;
      if (SEG !== S_0000) begin errors++; $display("FAIL held_start_seg: got %h want %h", SEG, S_0000); end
      PSW = 4'b0000;
      wait_neg(2);
      press(4'b1000);
      checks++;
      if (LED !== 8'h01) begin errors++; $display("FAIL restart_led: got %h want %h", LED, 8'h01); end
   endtask

   initial begin
      RST = 1'b1;
      PSW = 4'b0000;
      RSW = 4'b0000;
      test_reset();
      test_count();
      test_overflow();
      test_priority_clear();
      test_clear_in_run();
      test_laps();
      test_lap_full();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
